// File: rtl/alu_issue_sched.sv
// ALU reservation station: buffers dispatched ops, snoops ALU/LSB CDBs, issues one ready op per cycle (registered, 1-cycle).
// Backpressure via out_full; rdy=0 freezes state. Optional `ALU_SCHED_AGE_EN: oldest-ready select instead of lowest index.
module alu_issue_sched #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4,
  parameter int OP_W    = 6,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_flush,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_v1,
  input  logic [DATA_W-1:0] in_v2,
  input  logic [ROB_W-1:0]  in_q1,
  input  logic [ROB_W-1:0]  in_q2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [ROB_W-1:0]  in_rob_tag,
  output logic              out_full,
  input  logic [ROB_W-1:0]  cdb_alu_tag,
  input  logic [DATA_W-1:0] cdb_alu_val,
  input  logic [ROB_W-1:0]  cdb_lsb_tag,
  input  logic [DATA_W-1:0] cdb_lsb_val,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_value1,
  output logic [DATA_W-1:0] out_value2,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc,
  output logic [ROB_W-1:0]  out_rob_tag
);

  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CW = $clog2(RS_SIZE) + 1;

  logic [RS_SIZE-1:0] r_busy;
  logic [CW-1:0]      r_count;
  logic [OP_W-1:0]    r_op  [RS_SIZE];
  logic [DATA_W-1:0]  r_v1  [RS_SIZE];
  logic [DATA_W-1:0]  r_v2  [RS_SIZE];
  logic [ROB_W-1:0]   r_q1  [RS_SIZE];
  logic [ROB_W-1:0]   r_q2  [RS_SIZE];
  logic [DATA_W-1:0]  r_imm [RS_SIZE];
  logic [DATA_W-1:0]  r_pc  [RS_SIZE];
  logic [ROB_W-1:0]   r_rob [RS_SIZE];

`ifdef ALU_SCHED_AGE_EN
  localparam int SW = CW;
  logic [SW-1:0] r_stamp [RS_SIZE];
  logic [SW-1:0] r_stamp_ctr;
  logic [SW-1:0] w_best_stamp;

  // Outstanding stamps never differ by RS_SIZE or more, so the sign of the difference orders them.
  function automatic logic f_older(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] d;
    d = a - b;
    return d[SW-1];
  endfunction
`endif

  logic [RS_SIZE-1:0] w_ready;
  logic [IW-1:0]      w_sel_idx;
  logic               w_sel_vld;
  logic [IW-1:0]      w_free_idx;
  logic               w_disp;
  logic [DATA_W-1:0]  w_fwd_v1, w_fwd_v2;
  logic [ROB_W-1:0]   w_fwd_q1, w_fwd_q2;

  assign out_full = (r_count == CW'(RS_SIZE));
  assign w_disp   = in_valid && !out_full;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++)
      w_ready[i] = r_busy[i] && (r_q1[i] == '0) && (r_q2[i] == '0);
  end

  always_comb begin
    w_sel_idx = '0;
    w_sel_vld = 1'b0;
`ifdef ALU_SCHED_AGE_EN
    w_best_stamp = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (w_ready[i] && (!w_sel_vld || f_older(r_stamp[i], w_best_stamp))) begin
        w_sel_idx    = IW'(i);
        w_sel_vld    = 1'b1;
        w_best_stamp = r_stamp[i];
      end
    end
`else
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_ready[i]) begin
        w_sel_idx = IW'(i);
        w_sel_vld = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--)
      if (!r_busy[i]) w_free_idx = IW'(i);
  end

  // Operands produced this very cycle are captured at dispatch; ALU bus has priority.
  always_comb begin
    w_fwd_v1 = in_v1;
    w_fwd_q1 = in_q1;
    if (in_q1 != '0 && in_q1 == cdb_alu_tag) begin
      w_fwd_v1 = cdb_alu_val;
      w_fwd_q1 = '0;
    end else if (in_q1 != '0 && in_q1 == cdb_lsb_tag) begin
      w_fwd_v1 = cdb_lsb_val;
      w_fwd_q1 = '0;
    end
    w_fwd_v2 = in_v2;
    w_fwd_q2 = in_q2;
    if (in_q2 != '0 && in_q2 == cdb_alu_tag) begin
      w_fwd_v2 = cdb_alu_val;
      w_fwd_q2 = '0;
    end else if (in_q2 != '0 && in_q2 == cdb_lsb_tag) begin
      w_fwd_v2 = cdb_lsb_val;
      w_fwd_q2 = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy      <= '0;
      r_count     <= '0;
      out_op      <= '0;
      out_value1  <= '0;
      out_value2  <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rob_tag <= '0;
`ifdef ALU_SCHED_AGE_EN
      r_stamp_ctr <= '0;
`endif
    end else if (rdy && !in_flush && w_sel_vld) begin
      out_op      <= r_op[w_sel_idx];
      out_value1  <= r_v1[w_sel_idx];
      out_value2  <= r_v2[w_sel_idx];
      out_imm     <= r_imm[w_sel_idx];
      out_pc      <= r_pc[w_sel_idx];
      out_rob_tag <= r_rob[w_sel_idx];
      r_busy[w_sel_idx] <= 1'b0;
      if (w_disp) r_busy[w_free_idx] <= 1'b1;
      r_count <= r_count + CW'(w_disp) - CW'(1);
`ifdef ALU_SCHED_AGE_EN
      if (w_disp) r_stamp_ctr <= r_stamp_ctr + SW'(1);
`endif
    end else begin
      // Frozen, flushed or idle cycles all drive a NOP so no result gets rebroadcast.
      out_op      <= '0;
      out_value1  <= '0;
      out_value2  <= '0;
      out_imm     <= '0;
      out_pc      <= '0;
      out_rob_tag <= '0;
      if (rdy && in_flush) begin
        r_busy  <= '0;
        r_count <= '0;
`ifdef ALU_SCHED_AGE_EN
        r_stamp_ctr <= '0;
`endif
      end else if (rdy && w_disp) begin
        r_busy[w_free_idx] <= 1'b1;
        r_count <= r_count + CW'(1);
`ifdef ALU_SCHED_AGE_EN
        r_stamp_ctr <= r_stamp_ctr + SW'(1);
`endif
      end
    end
  end

  // Payload is only meaningful while busy, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !in_flush) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i]) begin
          if (r_q1[i] != '0 && r_q1[i] == cdb_alu_tag) begin
            r_v1[i] <= cdb_alu_val;
            r_q1[i] <= '0;
          end else if (r_q1[i] != '0 && r_q1[i] == cdb_lsb_tag) begin
            r_v1[i] <= cdb_lsb_val;
            r_q1[i] <= '0;
          end
          if (r_q2[i] != '0 && r_q2[i] == cdb_alu_tag) begin
            r_v2[i] <= cdb_alu_val;
            r_q2[i] <= '0;
          end else if (r_q2[i] != '0 && r_q2[i] == cdb_lsb_tag) begin
            r_v2[i] <= cdb_lsb_val;
            r_q2[i] <= '0;
          end
        end
      end
      if (w_disp) begin
        r_op[w_free_idx]  <= in_op;
        r_v1[w_free_idx]  <= w_fwd_v1;
        r_v2[w_free_idx]  <= w_fwd_v2;
        r_q1[w_free_idx]  <= w_fwd_q1;
        r_q2[w_free_idx]  <= w_fwd_q2;
        r_imm[w_free_idx] <= in_imm;
        r_pc[w_free_idx]  <= in_pc;
        r_rob[w_free_idx] <= in_rob_tag;
`ifdef ALU_SCHED_AGE_EN
        r_stamp[w_free_idx] <= r_stamp_ctr;
`endif
      end
    end
  end

endmodule

// File: doc/alu_issue_sched.md
Name: alu_issue_sched

Overview:
- Reservation-station scheduler that owns the single ALU.
- Buffers dispatched ALU/branch/jump ops and snoops the two CDB buses (ALU, LSB) to wake up pending operands.
- Each cycle it selects one ready entry and drives the ALU input bus with it (op, operands, imm, pc, ROB tag).
- Sits between the decoder/dispatch stage and the ALU; the ALU result returns to it via the ALU CDB.

Parameters:
- RS_SIZE, 16, number of entries (power of two, 2..32)
- ROB_W, 4, ROB tag width; tag 0 = "no tag / value ready"
- OP_W, 6, op-enum width; op 0 = NOP
- DATA_W, 32, data/address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global enable; low = freeze
- in_flush  in  1  misprediction rollback, clears all entries
- in_valid  in  1  dispatch strobe
- in_op  in  OP_W  op enum
- in_v1 / in_v2  in  DATA_W  operand values (meaningful when matching q is 0)
- in_q1 / in_q2  in  ROB_W  producer tags, 0 = ready
- in_imm  in  DATA_W  immediate
- in_pc  in  DATA_W  instruction pc
- in_rob_tag  in  ROB_W  destination ROB tag
- out_full  out  1  no free entry
- cdb_alu_tag / cdb_lsb_tag  in  ROB_W  broadcast tags, 0 = none
- cdb_alu_val / cdb_lsb_val  in  DATA_W  broadcast values
- out_op  out  OP_W  to ALU, 0 = NOP
- out_value1 / out_value2  out  DATA_W  to ALU
- out_imm  out  DATA_W  to ALU
- out_pc  out  DATA_W  to ALU
- out_rob_tag  out  ROB_W  to ALU

Behaviour:
- Reset (async, rst=1): all entries free; all outputs 0 (out_op=NOP, out_rob_tag=0); out_full=0.
- All state updates occur on the rising clk edge only when rdy=1 and rst=0.
- rdy=0: entry state held; ALU outputs registered to NOP/0 at that edge, so no result is rebroadcast.

Dispatch:
- When in_valid=1 and !out_full, write to the lowest-index free entry.
- Same-cycle forwarding: if in_qX == cdb_alu_tag or cdb_lsb_tag (nonzero), store that value with qX=0. If both buses match, the ALU bus wins.
- in_valid while out_full: the request is dropped; the dispatcher must not do this.

Wakeup:
- Every cycle, each busy entry with nonzero qX equal to a nonzero CDB tag captures the value and clears qX.

Select:
- Ready = busy && q1==0 && q2==0, evaluated on pre-edge state; an entry woken this cycle is ready next cycle.
- Policy: lowest index wins.
- At the edge, the winner's fields are registered onto the out_* bus and the entry is freed. If nothing is ready, drive out_op=NOP and out_rob_tag=0 (other outputs 0).
- Latency: dispatch at edge t (operands ready) -> earliest ALU drive after edge t+1. Throughput is 1 op/cycle.
- An entry freed at edge t can be reallocated by a dispatch at edge t+1. Issue and dispatch in the same cycle may target different entries.

out_full:
- Combinational from the registered count: out_full = (count == RS_SIZE).
- count tracks dispatch/issue both in the same cycle (net 0).

Flush:
- in_flush=1 (with rdy=1): at the edge, all entries are freed, outputs go to NOP/0 and count=0.
- Flush has priority over dispatch, issue and wakeup.

Mid-operation reset clears everything immediately, regardless of clk.

Optional Feature:
- ALU_SCHED_AGE_EN defined: each entry stores a dispatch sequence stamp. Select picks the ready entry with the oldest stamp, using wrap-safe comparison (stamp width = log2(RS_SIZE)+1). Ties are impossible. Flush resets the stamp counter.
- Not defined: lowest-index-ready select; no stamp storage.

Test Plan:
- Reset then dispatch ADD (op=ADD, v1=5, v2=7, q1=q2=0, rob=3) -> the cycle after the next edge shows out_op=ADD, out_value1=5, out_value2=7, out_rob_tag=3; the following cycle shows NOP.
- Dispatch with q1=2, then cdb_lsb_tag=2, val=0x100 two cycles later -> issue exactly one cycle after the broadcast with out_value1=0x100.
- Same-cycle forwarding: dispatch q2=4 while cdb_alu_tag=4, val=9 -> entry issues next cycle with out_value2=9.
- Fill 16 entries, all with q1=1 -> out_full=1; a 17th in_valid is dropped. Broadcast tag 1 -> entries issue in index order 0..15, one per cycle; out_full drops after the first issue.
- Hold 3 waiting entries, assert in_flush, then broadcast their tag -> no ALU op is ever issued and out_full=0.
- rdy=0 for 3 cycles with a ready entry present -> out_op=NOP throughout; the entry issues on the first edge after rdy returns to 1.
- With ALU_SCHED_AGE_EN: dispatch A to idx0 (waiting) then B to idx1 (ready), then wake A -> B issues first, then A.
